video_stream_gen: RTL and testbench

- Synthesizable frame source feeding the pixel-stream consumers: the bilinear scaler, and in simulation the frame dumper.
- Reads a stored frame through a simple synchronous read port (1-cycle latency) in raster order.
- Emits the codebase's standard stream: vsync/hsync/data_valid plus R/G/B, with configurable horizontal and vertical blanking.
- Supports single-shot and continuous frame generation.

---
 rtl/video_stream_gen_if.sv | 34 +++
 rtl/video_stream_gen.sv | 188 ++++++++++++++++++
 tb/tb_video_stream_gen.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/video_stream_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : video_stream_gen_if
//  Description : Memory read port and pixel stream bundle for video_stream_gen.
//                master = frame generator, slave = memory / stream consumer.
//  Revision    : 1.0  initial release
// ============================================================================
interface video_stream_gen_if #(
  parameter int PIXEL_WIDTH = 8,
  parameter int ADDR_WIDTH  = 19
);
  logic                       mem_rd;
  logic [ADDR_WIDTH-1:0]      mem_addr;
  logic [3*PIXEL_WIDTH-1:0]   mem_data;
  logic                       vsync;
  logic                       hsync;
  logic                       data_valid;
  logic [PIXEL_WIDTH-1:0]     data_r;
  logic [PIXEL_WIDTH-1:0]     data_g;
  logic [PIXEL_WIDTH-1:0]     data_b;

  modport master (
    output mem_rd, mem_addr,
    input  mem_data,
    output vsync, hsync, data_valid, data_r, data_g, data_b
  );

  modport slave (
    input  mem_rd, mem_addr,
    output mem_data,
    input  vsync, hsync, data_valid, data_r, data_g, data_b
  );
endinterface
`default_nettype wire

// File: rtl/video_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module      : video_stream_gen
//  Description : Raster-order frame source. Reads a stored frame through a
//                1-cycle-latency read port and emits vsync/hsync/data_valid
//                plus R/G/B with configurable horizontal/vertical blanking.
//                Single-shot or continuous generation.
//                Optional macro VSG_TEST_PATTERN_EN adds an internal
//                col/row test pattern selected per frame by i_pattern_en.
//  Revision    : 1.0  initial release
// ============================================================================
module video_stream_gen #(
  parameter     MODE        = "GRAYSCALE",
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int PIXEL_WIDTH = 8,
  parameter int H_BLANK     = 16,
  parameter int V_BLANK     = 32,
  parameter int ADDR_WIDTH  = 19
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_continuous,
`ifdef VSG_TEST_PATTERN_EN
  input  logic                i_pattern_en,
`endif
  video_stream_gen_if.master  io_vs,
  output logic                o_busy,
  output logic [31:0]         o_frame_count
);

  localparam int c_NPIX    = IMG_WIDTH * IMG_HEIGHT;
  localparam int c_CNT_MAX = (IMG_WIDTH > H_BLANK) ?
                             ((IMG_WIDTH > V_BLANK) ? IMG_WIDTH : V_BLANK) :
                             ((H_BLANK > V_BLANK) ? H_BLANK : V_BLANK);
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam int c_ROW_W   = $clog2(IMG_HEIGHT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_HSYNC  = 3'd2,
    S_ACTIVE = 3'd3,
    S_HBLANK = 3'd4,
    S_VBLANK = 3'd5
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [c_CNT_W-1:0]      r_cnt;
  logic [c_ROW_W-1:0]      r_row;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_busy;
  logic [31:0]             r_frame_count;
  logic                    r_vsync;
  logic                    r_hsync;
  logic                    r_valid;
  logic                    w_pat_on;
  logic                    w_vblank_last;
  logic [PIXEL_WIDTH-1:0]  w_mem_r;
  logic [PIXEL_WIDTH-1:0]  w_mem_g;
  logic [PIXEL_WIDTH-1:0]  w_mem_b;
  logic [PIXEL_WIDTH-1:0]  w_src_r;
  logic [PIXEL_WIDTH-1:0]  w_src_g;
  logic [PIXEL_WIDTH-1:0]  w_src_b;

  assign w_vblank_last = (r_state == S_VBLANK) && (r_cnt == c_CNT_W'(V_BLANK - 1));

  // Next-state selection: walk the raster timeline, blanking counts via r_cnt
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_state_next = S_VSYNC;
      S_VSYNC:  w_state_next = S_HSYNC;
      S_HSYNC:  w_state_next = S_ACTIVE;
      S_ACTIVE: if (r_cnt == c_CNT_W'(IMG_WIDTH - 1)) w_state_next = S_HBLANK;
      S_HBLANK: if (r_cnt == c_CNT_W'(H_BLANK - 1))
                  w_state_next = (r_row == c_ROW_W'(IMG_HEIGHT - 1)) ? S_VBLANK : S_HSYNC;
      S_VBLANK: if (w_vblank_last) w_state_next = i_continuous ? S_VSYNC : S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // State register plus position counters, frame counter and delayed strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_row         <= '0;
      r_addr        <= '0;
      r_busy        <= 1'b0;
      r_frame_count <= '0;
      r_vsync       <= 1'b0;
      r_hsync       <= 1'b0;
      r_valid       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != S_IDLE);
      // r_cnt restarts on every state change so each state counts from 0
      if ((w_state_next != r_state) || (r_state == S_IDLE))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
      if (r_state == S_VSYNC)
        r_row <= '0;
      else if ((r_state == S_HBLANK) && (w_state_next == S_HSYNC))
        r_row <= r_row + 1'b1;
      // Linear address saturates on the last pixel so it never leaves the frame
      if (r_state == S_VSYNC)
        r_addr <= '0;
      else if ((r_state == S_ACTIVE) && (r_addr != ADDR_WIDTH'(c_NPIX - 1)))
        r_addr <= r_addr + 1'b1;
      if (w_vblank_last)
        r_frame_count <= r_frame_count + 32'd1;
      r_vsync <= (r_state == S_VSYNC);
      r_hsync <= (r_state == S_HSYNC);
      r_valid <= (r_state == S_ACTIVE);
    end
  end

  if (MODE == "GRAYSCALE") begin : g_gray_mem
    logic w_unused_mem_hi;
    assign w_unused_mem_hi = ^io_vs.mem_data[3*PIXEL_WIDTH-1:PIXEL_WIDTH];
    assign w_mem_r = io_vs.mem_data[PIXEL_WIDTH-1:0];
    assign w_mem_g = io_vs.mem_data[PIXEL_WIDTH-1:0];
    assign w_mem_b = io_vs.mem_data[PIXEL_WIDTH-1:0];
  end else begin : g_rgb_mem
    assign w_mem_r = io_vs.mem_data[3*PIXEL_WIDTH-1:2*PIXEL_WIDTH];
    assign w_mem_g = io_vs.mem_data[2*PIXEL_WIDTH-1:PIXEL_WIDTH];
    assign w_mem_b = io_vs.mem_data[PIXEL_WIDTH-1:0];
  end

`ifdef VSG_TEST_PATTERN_EN
  logic                r_pat_en;
  logic [c_CNT_W-1:0]  r_pcol;
  logic [c_ROW_W-1:0]  r_prow;

  // Pattern select is frozen per frame; col/row are delayed to match r_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat_en <= 1'b0;
      r_pcol   <= '0;
      r_prow   <= '0;
    end else begin
      if (r_state == S_VSYNC)
        r_pat_en <= i_pattern_en;
      if (r_state == S_ACTIVE) begin
        r_pcol <= r_cnt;
        r_prow <= r_row;
      end
    end
  end

  assign w_pat_on = r_pat_en;

  if (MODE == "GRAYSCALE") begin : g_gray_pat
    logic w_unused_prow;
    assign w_unused_prow = ^r_prow;
    assign w_src_r = r_pat_en ? PIXEL_WIDTH'(r_pcol) : w_mem_r;
    assign w_src_g = r_pat_en ? PIXEL_WIDTH'(r_pcol) : w_mem_g;
    assign w_src_b = r_pat_en ? PIXEL_WIDTH'(r_pcol) : w_mem_b;
  end else begin : g_rgb_pat
    assign w_src_r = r_pat_en ? PIXEL_WIDTH'(r_pcol) : w_mem_r;
    assign w_src_g = r_pat_en ? PIXEL_WIDTH'(r_prow) : w_mem_g;
    assign w_src_b = r_pat_en ? (PIXEL_WIDTH'(r_pcol) ^ PIXEL_WIDTH'(r_prow)) : w_mem_b;
  end
`else
  assign w_pat_on = 1'b0;
  assign w_src_r  = w_mem_r;
  assign w_src_g  = w_mem_g;
  assign w_src_b  = w_mem_b;
`endif

  // Read data arrives in the same cycle as r_valid; zero it outside valid
  assign io_vs.mem_rd     = (r_state == S_ACTIVE) && !w_pat_on;
  assign io_vs.mem_addr   = r_addr;
  assign io_vs.vsync      = r_vsync;
  assign io_vs.hsync      = r_hsync;
  assign io_vs.data_valid = r_valid;
  assign io_vs.data_r     = r_valid ? w_src_r : '0;
  assign io_vs.data_g     = r_valid ? w_src_g : '0;
  assign io_vs.data_b     = r_valid ? w_src_b : '0;
  assign o_busy           = r_busy;
  assign o_frame_count    = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_video_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_stream_gen
//  Description : Self-checking bench for video_stream_gen (4x3 RGB frame).
//                Expected outputs come from a frame-timeline model computed
//                from the frame offset of each cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_video_stream_gen;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int HB   = 2;
  localparam int VB   = 3;
  localparam int PW   = 8;
  localparam int AW   = 4;
  localparam int LINE = 1 + W + HB;
  localparam int FLEN = 1 + H * LINE + VB;

  logic clk = 1'b0;
  logic rst;
  logic i_start;
  logic i_continuous;
  logic tb_pat;
  logic o_busy;
  logic [31:0] o_frame_count;

  video_stream_gen_if #(.PIXEL_WIDTH(PW), .ADDR_WIDTH(AW)) vs_if ();

  video_stream_gen #(
    .MODE("RGB"), .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_WIDTH(PW),
    .H_BLANK(HB), .V_BLANK(VB), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_start(i_start),
    .i_continuous(i_continuous),
`ifdef VSG_TEST_PATTERN_EN
    .i_pattern_en(tb_pat),
`endif
    .io_vs(vs_if),
    .o_busy(o_busy),
    .o_frame_count(o_frame_count)
  );

  always #5 clk = ~clk;

  // Frame store: 1-cycle read latency, random garbage when not reading
  logic [3*PW-1:0] memv [0:15];
  always @(posedge clk) begin
    if (vs_if.mem_rd) vs_if.mem_data <= memv[vs_if.mem_addr];
    else              vs_if.mem_data <= 24'($urandom);
  end

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Model state: offset within current frame (-1 = idle), frames done, pattern
  int   mk   = -1;
  int   mfc  = 0;
  logic mpat = 1'b0;

  // Observation counters
  int obs_busy, obs_valid, obs_hs, obs_vs, obs_rd;
  int obs_first_addr;
  logic [3*PW-1:0] obs_px21;
  int vs_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_obs();
    obs_busy = 0; obs_valid = 0; obs_hs = 0; obs_vs = 0; obs_rd = 0;
    obs_first_addr = -1; obs_px21 = '0;
    vs_q.delete();
  endtask

  task automatic rand_mem();
    for (int p = 0; p < 16; p++) memv[p] = 24'($urandom);
  endtask

  // One clock: advance the model, then compare every output against it
  task automatic step();
    logic s_in, c_in, r_in, p_in;
    logic e_busy, e_vs, e_hs, e_rd, e_dv;
    logic [AW-1:0] e_addr;
    logic [3*PW-1:0] e_px;
    int s, col;
    s_in = i_start; c_in = i_continuous; r_in = rst; p_in = tb_pat;
    @(posedge clk);
    #1;
    cyc++;
    if (r_in) begin
      mk = -1; mfc = 0;
    end else if (mk < 0) begin
      if (s_in) mk = 0;
    end else if (mk == FLEN - 1) begin
      mfc++;
      mk = c_in ? 0 : -1;
    end else begin
      mk++;
    end
`ifdef VSG_TEST_PATTERN_EN
    if (mk == 1) mpat = p_in;
`else
    mpat = 1'b0;
    if (p_in === 1'bx) mpat = 1'b0;
`endif
    e_busy = (mk >= 0); e_vs = (mk == 1); e_hs = 0; e_rd = 0; e_dv = 0;
    e_addr = '0; e_px = '0;
    if (mk >= 0) begin
      for (int l = 0; l < H; l++) begin
        s = 1 + l * LINE;
        if (mk == s + 1) e_hs = 1;
        if (mk >= s + 1 && mk <= s + W) begin
          e_rd = !mpat;
          e_addr = AW'(l * W + mk - s - 1);
        end
        if (mk >= s + 2 && mk <= s + W + 1) begin
          e_dv = 1;
          col = mk - s - 2;
          if (mpat) e_px = {col[7:0], l[7:0], col[7:0] ^ l[7:0]};
          else      e_px = memv[l * W + col];
        end
      end
    end
    check_eq("busy",   32'(o_busy), 32'(e_busy));
    check_eq("vsync",  32'(vs_if.vsync), 32'(e_vs));
    check_eq("hsync",  32'(vs_if.hsync), 32'(e_hs));
    check_eq("mem_rd", 32'(vs_if.mem_rd), 32'(e_rd));
    if (e_rd || r_in) check_eq("mem_addr", 32'(vs_if.mem_addr), 32'(e_addr));
    check_eq("valid",  32'(vs_if.data_valid), 32'(e_dv));
    check_eq("data_r", 32'(vs_if.data_r), 32'(e_px[23:16]));
    check_eq("data_g", 32'(vs_if.data_g), 32'(e_px[15:8]));
    check_eq("data_b", 32'(vs_if.data_b), 32'(e_px[7:0]));
    check_eq("fcount", o_frame_count, 32'(mfc));
    if (o_busy) obs_busy++;
    if (vs_if.hsync) obs_hs++;
    if (vs_if.vsync) begin obs_vs++; vs_q.push_back(cyc); end
    if (vs_if.mem_rd) begin
      if (obs_rd == 0) obs_first_addr = int'(vs_if.mem_addr);
      obs_rd++;
    end
    if (vs_if.data_valid) begin
      if (obs_valid == 1 * W + 2) obs_px21 = {vs_if.data_r, vs_if.data_g, vs_if.data_b};
      obs_valid++;
    end
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_continuous = 1'b0; tb_pat = 1'b0;
    for (int p = 0; p < 16; p++) memv[p] = '0;
    vs_if.mem_data = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Directed single-shot frame, address-derived memory contents
    for (int p = 0; p < 16; p++) memv[p] = {8'(p), 8'(p + 1), 8'(p + 2)};
    clear_obs();
    i_start = 1'b1; step(); i_start = 1'b0;
    repeat (30) step();
    check_eq("busy_cycles", 32'(obs_busy), 32'(FLEN));
    check_eq("valid_px",    32'(obs_valid), 32'(W * H));
    check_eq("hsync_cnt",   32'(obs_hs), 32'(H));
    check_eq("vsync_cnt",   32'(obs_vs), 32'd1);
    check_eq("rd_cnt",      32'(obs_rd), 32'(W * H));
    check_eq("frame1",      o_frame_count, 32'd1);

    // Start pulses during ACTIVE and VBLANK are ignored
    rand_mem();
    clear_obs();
    i_start = 1'b1; step(); i_start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      i_start = (i == 9 || i == 22);
      step();
    end
    i_start = 1'b0;
    check_eq("ign_busy", 32'(obs_busy), 32'(FLEN));
    check_eq("ign_idle", 32'(o_busy), 32'd0);

    // Three back-to-back frames in continuous mode
    rand_mem();
    clear_obs();
    i_continuous = 1'b1;
    i_start = 1'b1; step(); i_start = 1'b0;
    for (int i = 0; i < 85; i++) begin
      if (i == 60) i_continuous = 1'b0;
      step();
    end
    check_eq("cont_vs", 32'(vs_q.size()), 32'd3);
    for (int i = 1; i < vs_q.size(); i++)
      check_eq("cont_gap", 32'(vs_q[i] - vs_q[i - 1]), 32'(FLEN));
    check_eq("cont_busy", 32'(obs_busy), 32'(3 * FLEN));

    // Reset in the middle of line 1, then a clean restart
    i_start = 1'b1; step(); i_start = 1'b0;
    repeat (10) step();
    rst = 1'b1; step(); rst = 1'b0;
    check_eq("fc_rst", o_frame_count, 32'd0);
    clear_obs();
    i_start = 1'b1; step(); i_start = 1'b0;
    repeat (30) step();
    check_eq("restart_addr", 32'(obs_first_addr), 32'd0);

    // Randomized control traffic
    for (int i = 0; i < 400; i++) begin
      if (mk < 0 && ($urandom % 4) == 0) rand_mem();
      rst          = (($urandom % 150) == 0);
      i_start      = (($urandom % 6) == 0);
      i_continuous = 1'($urandom);
`ifdef VSG_TEST_PATTERN_EN
      if (mk < 0) tb_pat = 1'($urandom);
`endif
      step();
    end
    rst = 1'b0; i_start = 1'b0; i_continuous = 1'b0;
    repeat (FLEN + 5) step();

`ifdef VSG_TEST_PATTERN_EN
    // Internal test pattern
    tb_pat = 1'b1;
    clear_obs();
    i_start = 1'b1; step(); i_start = 1'b0;
    repeat (30) step();
    check_eq("pat_rd",  32'(obs_rd), 32'd0);
    check_eq("pat_px21", 32'(obs_px21), 32'({8'd2, 8'd1, 8'd3}));
    tb_pat = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
